// File: rtl/arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arbiter_pkg
// Shared types and constants for the three-requester grant arbiter.
//   state_t : FSM state encoding (IDLE / G1 / G2 / G3). Gk also serves as the
//             requester number k, so G3 doubles as the "last granted = 3"
//             pointer value.
//   NUM_REQ : number of requesters.
// ---------------------------------------------------------------------------
package arbiter_pkg;

    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G1   = 2'b01,
        G2   = 2'b10,
        G3   = 2'b11
    } state_t;

endpackage

// File: rtl/arb_prio_pick.sv
// ---------------------------------------------------------------------------
// arb_prio_pick
// Combinational priority pick for the arbiter FSM.
//   req  : request vector, bit 0 = requester 1
//   excl : requesters that must not be picked (bit 0 = requester 1)
//   ptr  : last-granted requester (G1..G3); the search starts at the
//          requester after it, wrapping 3 -> 1. ptr = G3 gives the fixed
//          order 1 > 2 > 3.
//   pick : grant state for the winning requester, IDLE if none qualifies
// ---------------------------------------------------------------------------
module arb_prio_pick
    import arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] excl,
    input  state_t             ptr,
    output state_t             pick
);

    logic [NUM_REQ-1:0] masked;
    logic [1:0]         order_idx [NUM_REQ];   // requester index tried at rank gi
    logic [NUM_REQ-1:0] order_hit;

    assign masked = req & ~excl;

    // Rank 0 is the requester right after ptr: with ptr holding requester k
    // (value k), index k (zero-based) is requester k+1.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_order
        assign order_idx[gi] = 2'((int'(ptr) + gi) % NUM_REQ);
        assign order_hit[gi] = masked[order_idx[gi]];
    end

    // Scan from lowest rank upward so the best-ranked hit is written last.
    always_comb begin
        pick = IDLE;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (order_hit[i]) begin
                pick = state_t'(order_idx[i] + 2'd1);
            end
        end
    end

endmodule

// File: rtl/arbiter_fsm.sv
// ---------------------------------------------------------------------------
// arbiter_fsm
// Three-requester Moore grant arbiter. A granted requester keeps the grant
// while it holds its request; with MAX_HOLD != 0 it is forced to hand over
// after MAX_HOLD consecutive grant cycles if someone else is waiting.
//
// Parameters:
//   MAX_HOLD : max consecutive grant cycles while another request is pending
//              (0 = unlimited). Must be < 2**HOLD_W.
//   HOLD_W   : hold counter width.
// Ports:
//   clk      : clock, rising edge
//   rstn     : synchronous reset, active HIGH (name kept for compatibility)
//   r1..r3   : request lines (level sensitive)
//   a1..a3   : registered one-hot grants
// Build option:
//   ARB_ROUND_ROBIN_EN : when defined, priority rotates starting after the
//   last granted requester; otherwise fixed priority r1 > r2 > r3.
// ---------------------------------------------------------------------------
module arbiter_fsm
    import arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 0,
    parameter int HOLD_W   = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic r1,
    input  logic r2,
    input  logic r3,
    output logic a1,
    output logic a2,
    output logic a3
);

    state_t             state;
    state_t             state_next;
    state_t             pick;
    state_t             ptr;
    logic [HOLD_W-1:0]  hold_cnt_reg;
    logic [HOLD_W-1:0]  hold_cnt_next;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] own_mask;
    logic               own_req;
    logic               others_req;
    logic               hold_expired;

    assign req = {r3, r2, r1};

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_own
        assign own_mask[gi] = (state == state_t'(2'(gi + 1)));
    end

    assign own_req    = |(req & own_mask);
    assign others_req = |(req & ~own_mask);

    // hold_cnt_reg counts grant cycles already completed by the current
    // holder, so the current cycle is number hold_cnt_reg + 1.
    assign hold_expired = (MAX_HOLD != 0) && ((int'(hold_cnt_reg) + 1) >= MAX_HOLD);

    // The current holder is always excluded. When it has released, its bit
    // is 0 anyway, so the same pick serves both release and expiry.
    arb_prio_pick u_pick (
        .req  (req),
        .excl (own_mask),
        .ptr  (ptr),
        .pick (pick)
    );

`ifdef ARB_ROUND_ROBIN_EN
    state_t ptr_reg;

    always_ff @(posedge clk) begin
        if (rstn) begin
            ptr_reg <= G3;
        end else if (state_next != IDLE) begin
            ptr_reg <= state_next;
        end
    end

    assign ptr = ptr_reg;
`else
    assign ptr = G3;
`endif

    always_comb begin
        state_next    = state;
        hold_cnt_next = '0;
        if (state == IDLE) begin
            state_next = pick;
        end else if (own_req) begin
            if (hold_expired && others_req) begin
                state_next = pick;
            end else begin
                hold_cnt_next = (hold_cnt_reg == '1) ? hold_cnt_reg : hold_cnt_reg + 1'b1;
            end
        end else begin
            state_next = pick;
        end
    end

    // Grants are registered from the next-state value, so they always equal
    // the decode of the current state with no input-to-output path.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state        <= IDLE;
            hold_cnt_reg <= '0;
            a1           <= 1'b0;
            a2           <= 1'b0;
            a3           <= 1'b0;
        end else begin
            state        <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            a1           <= (state_next == G1);
            a2           <= (state_next == G2);
            a3           <= (state_next == G3);
        end
    end

endmodule

// File: tb/tb_arbiter_fsm.sv
// ---------------------------------------------------------------------------
// tb_arbiter_fsm
// Drives two arbiter instances (MAX_HOLD = 0 and MAX_HOLD = 2) with the same
// request/reset stimulus: directed scenarios first, then random traffic.
// A behavioural model tracks who owns the resource and for how many cycles;
// expected owners are queued at each edge and a monitor checks grants, the
// state register and one-hotness on the following falling edge.
// ---------------------------------------------------------------------------
module tb_arbiter_fsm;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn, r1, r2, r3;
    logic u_a1, u_a2, u_a3;
    logic h_a1, h_a2, h_a3;

    always #5 clk = ~clk;

    arbiter_fsm #(.MAX_HOLD(0), .HOLD_W(8)) dut_u (
        .clk(clk), .rstn(rstn), .r1(r1), .r2(r2), .r3(r3),
        .a1(u_a1), .a2(u_a2), .a3(u_a3)
    );

    arbiter_fsm #(.MAX_HOLD(2), .HOLD_W(8)) dut_h (
        .clk(clk), .rstn(rstn), .r1(r1), .r2(r2), .r3(r3),
        .a1(h_a1), .a2(h_a2), .a3(h_a3)
    );

    typedef struct {
        int         owner;   // 0 = nobody, else requester number
        int         held;    // grant cycles the owner has had so far
        int         last;    // last requester granted
    } mdl_t;

    typedef struct {
        int         cyc;
        logic [3:1] req;
        logic       rst;
        int         own_u;
        int         own_h;
    } exp_t;

    exp_t sb_q[$];
    mdl_t m_u = '{0, 0, 3};
    mdl_t m_h = '{0, 0, 3};
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Highest-priority asserted requester other than excl; priority starts
    // after "last" (last = 3 reproduces the fixed order 1 > 2 > 3).
    function automatic int pick(logic [3:1] req, int excl, int last);
        for (int i = 1; i <= 3; i++) begin
            int c;
            c = ((last + i - 1) % 3) + 1;
            if (req[c] && c != excl) return c;
        end
        return 0;
    endfunction

    function automatic mdl_t step(mdl_t m, logic rst, logic [3:1] req, int maxh);
        mdl_t n;
        int   alt;
        n = m;
        if (rst) begin
            n.owner = 0;
            n.held  = 0;
            n.last  = 3;
            return n;
        end
        if (m.owner != 0 && req[m.owner]) begin
            alt = pick(req, m.owner, m.last);
            if (maxh != 0 && m.held >= maxh && alt != 0) begin
                n.owner = alt;
                n.held  = 1;
            end else begin
                n.held = m.held + 1;
            end
        end else begin
            n.owner = pick(req, 0, m.last);
            n.held  = (n.owner != 0) ? 1 : 0;
        end
        if (RR && n.owner != 0) n.last = n.owner;
        return n;
    endfunction

    function automatic logic [7:0] gvec(int o);
        return (o == 0) ? 8'd0 : 8'(1 << (o - 1));
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: apply inputs, let the edge happen, record the expectation.
    task automatic cycle(input logic rst, input logic [3:1] req);
        rstn = rst;
        {r3, r2, r1} = req;
        @(posedge clk);
        m_u = step(m_u, rst, req, 0);
        m_h = step(m_h, rst, req, 2);
        sb_q.push_back('{cyc, req, rst, m_u.owner, m_h.owner});
        cyc++;
        #1;
    endtask

    // Monitor: one check set per recorded edge, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                $display("cyc %0d rst=%b req(r3r2r1)=%b exp_u=%0d exp_h=%0d got_u=%b%b%b got_h=%b%b%b",
                         e.cyc, e.rst, e.req, e.own_u, e.own_h,
                         u_a3, u_a2, u_a1, h_a3, h_a2, h_a1);
                chk("u_grant",  8'({u_a3, u_a2, u_a1}), gvec(e.own_u));
                chk("h_grant",  8'({h_a3, h_a2, h_a1}), gvec(e.own_h));
                chk("u_state",  8'(dut_u.state), 8'(e.own_u));
                chk("h_state",  8'(dut_h.state), 8'(e.own_h));
                chk("u_onehot", 8'($countones({u_a3, u_a2, u_a1}) <= 1), 8'd1);
                chk("h_onehot", 8'($countones({h_a3, h_a2, h_a1}) <= 1), 8'd1);
            end
        end
    end

    initial begin
        logic [3:1] rq;
        rstn = 1'b1;
        {r3, r2, r1} = 3'b000;

        // reset, then single-cycle pulses on each requester
        repeat (2) cycle(1'b1, 3'b000);
        cycle(1'b0, 3'b000);
        cycle(1'b0, 3'b001);
        repeat (2) cycle(1'b0, 3'b000);
        cycle(1'b0, 3'b010);
        cycle(1'b0, 3'b000);
        cycle(1'b0, 3'b100);
        cycle(1'b0, 3'b000);

        // simultaneous requests from idle
        cycle(1'b0, 3'b011);
        cycle(1'b0, 3'b000);
        cycle(1'b0, 3'b110);
        cycle(1'b0, 3'b000);
        cycle(1'b0, 3'b111);
        cycle(1'b0, 3'b000);

        // r1 held, r2 raised mid-hold, r1 released: direct handover
        repeat (3) cycle(1'b0, 3'b001);
        repeat (3) cycle(1'b0, 3'b011);
        repeat (2) cycle(1'b0, 3'b010);
        cycle(1'b0, 3'b000);

        // reset in the middle of a grant, then re-grant
        repeat (2) cycle(1'b0, 3'b001);
        cycle(1'b1, 3'b001);
        repeat (2) cycle(1'b0, 3'b001);
        cycle(1'b0, 3'b000);

        // low-priority holder with r1 pending: hold limit on dut_h
        cycle(1'b0, 3'b100);
        repeat (5) cycle(1'b0, 3'b101);
        cycle(1'b0, 3'b000);

        // everyone requesting continuously, then with releases
        repeat (6) cycle(1'b0, 3'b111);
        cycle(1'b0, 3'b110);
        cycle(1'b0, 3'b111);
        cycle(1'b0, 3'b101);
        cycle(1'b0, 3'b111);
        cycle(1'b0, 3'b011);
        repeat (3) cycle(1'b0, 3'b111);
        cycle(1'b0, 3'b000);

        // random traffic with occasional resets
        rq = 3'b000;
        for (int i = 0; i < 400; i++) begin
            for (int b = 1; b <= 3; b++) begin
                if ($urandom_range(3) == 0) rq[b] = ~rq[b];
            end
            cycle($urandom_range(49) == 0, rq);
        end

        repeat (2) cycle(1'b0, 3'b000);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arbiter_fsm.md
Name: arbiter_fsm

Overview:
- Three-requester grant arbiter built as a Moore FSM.
- Samples request lines r1..r3 and issues exactly one registered, one-hot grant a1..a3.
- A granted requester keeps the grant while it holds its request.
- Sits between up to three bus/resource masters and a shared resource; there is no downstream handshake other than request/grant.

Parameters:
- MAX_HOLD, default 0: max consecutive grant cycles while another request is pending; 0 = unlimited hold.
- HOLD_W, default 8: width of the hold counter; MAX_HOLD must be < 2**HOLD_W.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rstn  input  1  synchronous, active-high reset (asserted when 1; port name kept per codebase)
- r1  input  1  request from master 1
- r2  input  1  request from master 2
- r3  input  1  request from master 3
- a1  output  1  grant to master 1, registered
- a2  output  1  grant to master 2, registered
- a3  output  1  grant to master 3, registered

Behaviour:
- State register, 2 bits, internal name `state` (probed hierarchically by the bench). Encoding: IDLE=2'b00, G1=2'b01, G2=2'b10, G3=2'b11.
- Outputs are decoded from `state` only:
  - a1=(state==G1), a2=(state==G2), a3=(state==G3).
  - At most one grant is high at any time.
- Reset: when rstn=1 at a rising edge, next state is IDLE, all grants are 0 and the hold counter clears. Reset overrides everything, including mid-grant.
- Latency: a request sampled at edge N gives its grant visible after edge N; release sampled at edge M drops the grant after edge M.
- Priority pick (default): r1 > r2 > r3.
- From IDLE:
  - go to the highest-priority asserted request;
  - with no request, stay in IDLE.
- From Gk while rk=1:
  - stay in Gk (hold) and increment the hold counter, saturating;
  - if MAX_HOLD≠0, the counter has reached MAX_HOLD and another request is pending, move to the highest-priority pending requester other than k, and clear the counter.
- From Gk with rk=0:
  - re-arbitrate directly among current requests using the priority pick (no IDLE bubble);
  - with no request, go to IDLE; clear the counter.
- Simultaneous requests in IDLE: r1&r2 → G1; r2&r3 → G2; r1&r2&r3 → G1.
- A lower-priority holder is not pre-empted by a newly raised higher-priority request until it releases, or until the MAX_HOLD expiry.
- Requests are level-sensitive. Single-cycle pulses are granted for exactly one cycle.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: the priority pick rotates. It starts at the requester after the last granted one, wrapping 3→1. The last-granted pointer resets to 3 (so the first pick after reset is r1 > r2 > r3) and updates on every entry into Gk.
- Undefined: fixed r1 > r2 > r3 priority, and no pointer register exists.
- All other rules (hold, MAX_HOLD, reset) are identical in both builds.

Decomposition:
- Package arbiter_pkg holds:
  - state typedef/localparams IDLE/G1/G2/G3;
  - the requester count constant (3).
- One natural sub-module: arb_prio_pick. It is combinational; inputs are the request vector, an exclusion mask and the rotation pointer; output is the next grant state.
- The FSM, hold counter and output decode stay in arbiter_fsm.

Test Plan:
- Reset for 2 cycles with all requests 0 → state=00, a1=a2=a3=0. Then pulse r1 for one cycle → a1=1 for exactly one cycle, then state returns to 00.
- r2 alone one cycle, then r3 alone one cycle → state=10/a2=1, then state=11/a3=1, each for one cycle.
- r1=r2=1 together → a1=1, a2=0. r2=r3=1 → a2=1. r1=r2=r3=1 → a1=1 only. Check one-hot on every cycle.
- r1 held for 3+ cycles with r2 raised mid-hold (MAX_HOLD=0) → a1 stays 1 throughout. On r1 drop, the next edge gives a2=1 directly, with no IDLE cycle.
- rstn=1 asserted while state=G1 with r1=1 → the next edge gives state=00 and all grants 0. After rstn=0 with r1=1 → a1=1 one edge later.
- MAX_HOLD=2, r3 held with r1 pending → a3 high for 2 cycles, then a1=1. With ARB_ROUND_ROBIN_EN, run r1=r2=r3=1 continuously with releases: grants rotate 1→2→3→1.
